// File: rtl/jitype_emit_if.sv
// Request, control and instruction-memory write signals of the JI-type stub emitter.
// The master side drives requests and memory back-pressure; the slave side is the emitter.
`timescale 1ns/1ps
interface jitype_emit_if #(
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [26:0]       in_target;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              imem_busy;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              running;
   logic              wrapped;
   logic [15:0]       emit_count;

   modport master (
      output in_valid, in_kind, in_target, start, start_addr, imem_busy,
      input  in_ready, imem_we, imem_addr, imem_data, running, wrapped, emit_count
   );

   modport slave (
      input  in_valid, in_kind, in_target, start, start_addr, imem_busy,
      output in_ready, imem_we, imem_addr, imem_data, running, wrapped, emit_count
   );
endinterface

// File: rtl/jitype_emit.sv
// Encodes J-class requests (j, jal, bex, setx) into 32-bit words, buffers them in a FIFO
// and writes them to consecutive instruction-memory addresses once started.
`timescale 1ns/1ps
module jitype_emit #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   jitype_emit_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       fifo_mem [DEPTH];
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_data_q;
   logic              running_q;
   logic              wrapped_q;
   logic [15:0]       emit_count_q;
   logic              full, empty, push, pop, load;

   function automatic logic [31:0] encode(input logic [1:0] kind, input logic [26:0] t);
      logic [4:0] op;
      case (kind)
         2'd0:    op = 5'b00001;
         2'd1:    op = 5'b00011;
         2'd2:    op = 5'b10110;
         default: op = 5'b10101;
      endcase
      return {op, t};
   endfunction

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push  = bus.in_valid && bus.in_ready;

   // Held low while in reset so nothing is offered as accepted.
   assign bus.in_ready   = reset_n && !full;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_data  = imem_data_q;
   assign bus.running    = running_q;
   assign bus.wrapped    = wrapped_q;
   assign bus.emit_count = emit_count_q;

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= encode(bus.in_kind, bus.in_target);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pop     = 1'b0;
      load    = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (bus.start) begin
               state_d = ST_RUN;
               addr_d  = bus.start_addr;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            if (!empty && !bus.imem_busy) begin
               pop    = 1'b1;
               addr_d = addr_q + 1'b1;
               if (&addr_q) begin
                  state_d = ST_HALT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         addr_q       <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_data_q  <= '0;
         running_q    <= 1'b0;
         wrapped_q    <= 1'b0;
         emit_count_q <= '0;
      end else begin
         addr_q    <= addr_d;
         imem_we_q <= pop;
         running_q <= (state_d == ST_RUN);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            imem_addr_q <= addr_q;
            imem_data_q <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
            if (emit_count_q != 16'hFFFF) begin
               emit_count_q <= emit_count_q + 1'b1;
            end
            if (&addr_q) begin
               wrapped_q <= 1'b1;
            end
         end
         if (load) begin
            emit_count_q <= '0;
            wrapped_q    <= 1'b0;
         end
      end
   end
endmodule
